led_pattern_seq: RTL and testbench

Parametrised LED pattern sequencer for iCE40 boards. A prescaled step counter walks an address through an inferred block-RAM pattern table, and the registered read data drives the LEDs. It generalises the free-running-counter-into-ROM scheme with:
- configurable width, depth and step rate;
- four walk modes and a programmable sequence end;
- a runtime write port for reloading patterns.

---
 rtl/led_pattern_seq.sv | 149 ++++++++++++++
 tb/tb_led_pattern_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_seq
// Brief    : Prescaled address walker over a writable pattern table driving LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_seq #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int PRESCALE   = 4194304
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DEPTH_LOG2-1:0] last,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      leds,
    output logic [DEPTH_LOG2-1:0] addr,
    output logic                  step
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]         PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]         PRESC_ONE = PW'(1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_PING = 2'd2;

    typedef logic [WIDTH-1:0] table_t [0:DEPTH-1];

    function automatic table_t gray_fill();
        table_t t;
        for (int i = 0; i < DEPTH; i++) begin
            t[i] = WIDTH'(i ^ (i >> 1));
        end
        return t;
    endfunction

    // Power-up contents only; reset never touches the table.
    table_t r_mem = gray_fill();

    logic [PW-1:0]         r_presc;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic                  r_dir_down;
    logic                  r_tick;
    logic [WIDTH-1:0]      r_leds;
    logic                  r_step;

    logic                  w_tick;
    logic [DEPTH_LOG2-1:0] w_addr_nx;
    logic                  w_dir_nx;

    assign w_tick = en && (r_presc == PRESC_MAX);

    always_comb begin
        w_addr_nx = r_addr;
        w_dir_nx  = r_dir_down;
        if (w_tick) begin
            case (mode)
                MODE_UP: begin
                    if (r_addr > last) begin
                        w_addr_nx = ADDR_ZERO;
                        w_dir_nx  = 1'b0;
                    end else if (r_addr == last) begin
                        w_addr_nx = ADDR_ZERO;
                    end else begin
                        w_addr_nx = r_addr + ADDR_ONE;
                    end
                end
                MODE_DOWN: begin
                    if (r_addr > last || r_addr == ADDR_ZERO) begin
                        w_addr_nx = last;
                    end else begin
                        w_addr_nx = r_addr - ADDR_ONE;
                    end
                end
                MODE_PING: begin
                    if (r_addr > last) begin
                        w_addr_nx = ADDR_ZERO;
                        w_dir_nx  = 1'b0;
                    end else if (!r_dir_down) begin
                        // A single-entry sequence never turns around.
                        if (r_addr == last) begin
                            if (last != ADDR_ZERO) begin
                                w_addr_nx = r_addr - ADDR_ONE;
                                w_dir_nx  = 1'b1;
                            end
                        end else begin
                            w_addr_nx = r_addr + ADDR_ONE;
                        end
                    end else begin
                        if (r_addr == ADDR_ZERO) begin
                            w_dir_nx = 1'b0;
                            if (last != ADDR_ZERO) begin
                                w_addr_nx = ADDR_ONE;
                            end
                        end else begin
                            w_addr_nx = r_addr - ADDR_ONE;
                        end
                    end
                end
                default: begin
                    w_addr_nx = r_addr;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc    <= '0;
            r_addr     <= '0;
            r_dir_down <= 1'b0;
            r_tick     <= 1'b0;
            r_leds     <= '0;
            r_step     <= 1'b0;
        end else begin
            if (en) begin
                r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
            end
            r_addr     <= w_addr_nx;
            r_dir_down <= w_dir_nx;
            r_tick     <= w_tick;
            r_leds     <= r_mem[r_addr];
            // step lines up with the leds update, one cycle after addr moves.
            r_step     <= r_tick;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign leds = r_leds;
    assign addr = r_addr;
    assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_seq
// Brief    : Scoreboard bench for led_pattern_seq (WIDTH=8, DEPTH_LOG2=4, PRESCALE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic [1:0] mode;
    logic [3:0] last;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] leds;
    logic [3:0] addr;
    logic       step;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .WIDTH      (8),
        .DEPTH_LOG2 (4),
        .PRESCALE   (4)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en),
        .mode    (mode),
        .last    (last),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .leds    (leds),
        .addr    (addr),
        .step    (step)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] l;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   step_prev = 0;
    int   step_last = 0;
    int   c0;

    // Expected table image: Gray code, patched by the bench's own writes.
    logic [7:0] tbl [16];
    initial tbl = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04,
                    8'h0C, 8'h0D, 8'h0F, 8'h0E, 8'h0A, 8'h0B, 8'h09, 8'h08};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int a);
        sb.push_back(exp_t'({4'(a), tbl[a]}));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected steps never arrived, required 0 pending", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every step pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            step_prev = step_last;
            step_last = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: step seen at addr %0h leds %0h, none required", addr, leds);
            end else begin
                m_e = sb.pop_front();
                check("step_addr", 32'(addr), 32'(m_e.a));
                check("step_leds", 32'(leds), 32'(m_e.l));
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        en      = 1'b0;
        mode    = 2'd0;
        last    = 4'd15;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'h00;

        // Reset and Gray up-walk
        repeat (3) @(negedge clk);
        check("rst_leds", 32'(leds), 32'h00);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        en     = 1'b1;
        resetn = 1'b1;
        for (int i = 1; i < 16; i++) push(i);
        push(0);
        @(posedge clk);
        #1;
        check("rel_leds", 32'(leds), 32'h00);
        check("rel_step", 32'(step), 32'h0);
        drain("up_walk");
        check("step_period", 32'(step_last - step_prev), 32'd4);

        // Down wrap from 0
        mode = 2'd1;
        push(15); push(14); push(13);
        drain("down_walk");

        // Back to 0, then ping-pong over 0..3
        mode = 2'd0;
        push(14); push(15); push(0);
        drain("up_to_zero");
        mode = 2'd2;
        last = 4'd3;
        push(1); push(2); push(3); push(2); push(1); push(0); push(1);
        drain("ping_pong");

        // last=0: out-of-range snaps to 0, then stays there
        last = 4'd0;
        push(0); push(0); push(0);
        drain("last_zero");

        // Runtime last lowered below addr, up mode
        mode = 2'd0;
        last = 4'd15;
        for (int i = 1; i <= 10; i++) push(i);
        drain("up_to_10a");
        last = 4'd5;
        push(0); push(1); push(2); push(3); push(4); push(5); push(0);
        drain("up_oor");

        // Runtime last lowered below addr, down mode
        last = 4'd15;
        for (int i = 1; i <= 10; i++) push(i);
        drain("up_to_10b");
        mode = 2'd1;
        last = 4'd5;
        push(5); push(4);
        drain("down_oor");

        // Enable dropped mid-step: everything frozen
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_addr", 32'(addr), 32'h4);
        push(3);
        c0 = cyc;
        en = 1'b1;
        drain("resume");
        check("resume_phase", 32'(step_last - c0), 32'd3);

        // Hold mode keeps stepping without moving
        mode = 2'd3;
        push(3); push(3); push(3);
        drain("hold_mode");

        // Write port
        mode = 2'd1;
        push(2);
        drain("to_addr2");
        en      = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = 8'hA5;
        tbl[2]  = 8'hA5;
        @(posedge clk);
        #1;
        check("wr_old_data", 32'(leds), 32'h03);
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        check("wr_new_data", 32'(leds), 32'hA5);
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = 8'h3C;
        tbl[7]  = 8'h3C;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("wr_other_addr", 32'(leds), 32'hA5);
        @(negedge clk);
        mode = 2'd0;
        last = 4'd15;
        en   = 1'b1;
        push(3); push(4); push(5); push(6); push(7);
        drain("wr_seen_at7");

        // Ping-pong up to 15 and back down to 9, then async reset
        mode = 2'd2;
        for (int i = 8; i <= 15; i++) push(i);
        for (int i = 14; i >= 9; i--) push(i);
        drain("pp_to_9");
        #2;
        resetn = 1'b0;
        #1;
        check("arst_leds", 32'(leds), 32'h00);
        check("arst_addr", 32'(addr), 32'h0);
        check("arst_step", 32'(step), 32'h0);
        @(negedge clk);
        @(negedge clk);
        push(1); push(2); push(3);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("arel_leds", 32'(leds), 32'h00);
        check("arel_step", 32'(step), 32'h0);
        check("arel_addr", 32'(addr), 32'h0);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
